// File: rtl/ld_st_unit_pkg.sv
// Shared types and defaults for the load/store unit.
package ld_st_unit_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } ls_state_t;

  localparam int TMO_DEF = 15;
  localparam int AW_DEF  = 8;

  // Register address width for a given register pointer parameter
  function automatic int reg_addr_w(input int pw);
    return pw + 1;
  endfunction

endpackage

// File: rtl/ld_st_unit_ls_addr_gen.sv
// Effective address: base plus sign-extended 4-bit offset, wrapping modulo 2^AW.
module ls_addr_gen #(
  parameter int AW = 8
) (
  input  logic [7:0]    base,
  input  logic [3:0]    offset,
  output logic [AW-1:0] addr
);

  // Sum width covers both the 8-bit base and the address, so truncation
  // to AW bits gives the modulo-2^AW result in either direction.
  localparam int SW = (AW > 8) ? AW : 8;

  logic [SW-1:0] base_ext_s;
  logic [SW-1:0] off_ext_s;
  logic [SW-1:0] sum_s;

  // Zero-extend base, sign-extend offset, add and keep the low AW bits
  always_comb begin
    base_ext_s = SW'(base);
    off_ext_s  = SW'(signed'(offset));
    sum_s      = base_ext_s + off_ext_s;
    addr       = sum_s[AW-1:0];
  end

endmodule

// File: rtl/ld_st_unit.sv
// Load/store stage: one memory access per command with a bounded ack wait,
// load data returned through the register-file write port.
module ld_st_unit
  import ld_st_unit_pkg::*;
#(
  parameter int pw  = 4,
  parameter int AW  = AW_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          is_store,
  input  logic [7:0]    base,
  input  logic [3:0]    offset,
  input  logic [7:0]    st_data,
  input  logic [pw:0]   dst_addr,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  input  logic          mem_ack,
  output logic          rf_wr_en,
  output logic [pw:0]   rf_wr_addr,
  output logic [7:0]    rf_dat
);

  localparam int RW = reg_addr_w(pw);

  // Counter value on the last unacknowledged REQ cycle before abort
  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  ls_state_t     state_r;
  logic [7:0]    cnt_r;
  logic          is_store_r;
  logic [RW-1:0] dst_r;
  logic          busy_r;
  logic          done_r;
  logic          err_r;
  logic          mem_req_r;
  logic          mem_we_r;
  logic [AW-1:0] mem_addr_r;
  logic [7:0]    mem_wdata_r;
  logic          rf_wr_en_r;
  logic [RW-1:0] rf_wr_addr_r;
  logic [7:0]    rf_dat_r;
  logic [AW-1:0] addr_s;

  ls_addr_gen #(.AW(AW)) u_addr_gen (
    .base   (base),
    .offset (offset),
    .addr   (addr_s)
  );

  // Access sequencer with counter and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= 8'd0;
      is_store_r   <= 1'b0;
      dst_r        <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= 8'd0;
      rf_wr_en_r   <= 1'b0;
      rf_wr_addr_r <= '0;
      rf_dat_r     <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r     <= 1'b0;
          rf_wr_en_r <= 1'b0;
          if (start) begin
            is_store_r  <= is_store;
            dst_r       <= dst_addr;
            mem_addr_r  <= addr_s;
            mem_wdata_r <= st_data;
            mem_we_r    <= is_store;
            mem_req_r   <= 1'b1;
            busy_r      <= 1'b1;
            err_r       <= 1'b0;
            cnt_r       <= 8'd0;
            state_r     <= REQ;
          end
        end
        REQ: begin
          // An ack on the final allowed cycle takes priority over the abort
          if (mem_ack) begin
            if (!is_store_r) begin
              rf_dat_r <= mem_rdata;
            end
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
            state_r   <= RESP;
          end else if (cnt_r == TMO_LAST) begin
            err_r     <= 1'b1;
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
            state_r   <= RESP;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        RESP: begin
          done_r       <= 1'b1;
          rf_wr_en_r   <= ~is_store_r & ~err_r;
          rf_wr_addr_r <= dst_r;
          busy_r       <= 1'b0;
          state_r      <= IDLE;
        end
        default: begin
          state_r    <= IDLE;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
          mem_req_r  <= 1'b0;
          mem_we_r   <= 1'b0;
          rf_wr_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign rf_wr_en   = rf_wr_en_r;
  assign rf_wr_addr = rf_wr_addr_r;
  assign rf_dat     = rf_dat_r;

endmodule

// File: tb/tb_ld_st_unit.sv
// Scoreboard bench for ld_st_unit: stimulus pushes expected memory requests
// and completions; a memory model and a completion monitor pop and compare.
module tb_ld_st_unit;

  localparam int PW  = 4;
  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       is_store = 1'b0;
  logic [7:0] base = 8'd0;
  logic [3:0] offset = 4'd0;
  logic [7:0] st_data = 8'd0;
  logic [4:0] dst_addr = 5'd0;
  logic       busy, done, err, mem_req, mem_we, rf_wr_en;
  logic [7:0] mem_addr, mem_wdata, rf_dat;
  logic [4:0] rf_wr_addr;
  logic [7:0] mem_rdata = 8'd0;
  logic       mem_ack = 1'b0;

  always #5 clk = ~clk;

  ld_st_unit #(.pw(PW), .AW(8), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
    .base(base), .offset(offset), .st_data(st_data), .dst_addr(dst_addr),
    .busy(busy), .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
    .rf_dat(rf_dat)
  );

  typedef struct {
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
    int         delay;
    logic [7:0] rdata;
    int         cycles;
  } req_t;

  typedef struct {
    logic       err;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] dat;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  req_t cur;
  bit   active = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: checks each request cycle and acks after the programmed delay
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (rst_n && mem_req) begin
      if (!active) begin
        active = 1'b1;
        cyc = 0;
        if (req_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL req_q: unexpected memory request at %0t", $time);
          cur = '{8'd0, 1'b0, 8'd0, 0, 8'd0, 1};
        end else begin
          cur = req_q.pop_front();
        end
      end
      chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
      chk("mem_we", 32'(mem_we), 32'(cur.we));
      if (cur.we) chk("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
      if (cyc == cur.delay) begin
        mem_ack   = 1'b1;
        mem_rdata = cur.rdata;
      end
      cyc++;
    end else if (active) begin
      active = 1'b0;
      if (rst_n) chk("req_cycles", 32'(cyc), 32'(cur.cycles));
    end
  end

  // Completion monitor plus per-cycle output invariants
  always @(negedge clk) begin
    if (rst_n) begin
      if (rf_wr_en === 1'b1 && done !== 1'b1) begin
        tests++; fails++;
        $display("FAIL wr_en_outside_resp: rf_wr_en=1 done=%b at %0t", done, $time);
      end
      if (mem_we === 1'b1 && mem_req !== 1'b1) begin
        tests++; fails++;
        $display("FAIL we_without_req: mem_we=1 mem_req=%b at %0t", mem_req, $time);
      end
      if (done === 1'b1) begin
        if (rsp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rsp_q: unexpected done at %0t", $time);
        end else begin
          rsp_t e;
          e = rsp_q.pop_front();
          chk("done_err", 32'(err), 32'(e.err));
          chk("done_wr_en", 32'(rf_wr_en), 32'(e.wr_en));
          chk("done_busy", 32'(busy), 32'd0);
          if (e.wr_en) begin
            chk("rf_wr_addr", 32'(rf_wr_addr), 32'(e.wr_addr));
            chk("rf_dat", 32'(rf_dat), 32'(e.dat));
          end
        end
      end
    end
  end

  // Issue one command at a negedge and wait (bounded) for its done pulse
  task automatic issue(input bit st, input logic [7:0] b, input logic [3:0] off,
                       input logic [7:0] sd, input logic [4:0] dst, input int delay,
                       input logic [7:0] rd, input logic [7:0] exp_addr,
                       input bit exp_err, input bit glitch);
    req_t r;
    rsp_t p;
    int   lat;
    r = '{exp_addr, st, sd, delay, rd, exp_err ? TMO : delay + 1};
    p = '{exp_err, ~st & ~exp_err, dst, rd};
    req_q.push_back(r);
    rsp_q.push_back(p);
    start = 1'b1; is_store = st; base = b; offset = off; st_data = sd; dst_addr = dst;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("err_cleared", 32'(err), 32'd0);
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      start = glitch && (i < 2);
      if (glitch) begin
        base = 8'hAA; is_store = ~st; dst_addr = 5'd0;
      end
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    chk("latency", 32'(lat), exp_err ? 32'(TMO + 1) : 32'(delay + 2));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctrl", 32'({busy, done, err, mem_req, mem_we, rf_wr_en}), 32'd0);
    chk("reset_data", 32'({mem_addr, mem_wdata, rf_wr_addr, rf_dat}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Load, immediate ack: 0x10 + 2
    issue(1'b0, 8'h10, 4'd2, 8'h00, 5'd3, 0, 8'hA5, 8'h12, 1'b0, 1'b0);
    // Store, ack in 4th cycle: 0x40 - 1
    issue(1'b1, 8'h40, 4'hF, 8'h5C, 5'd0, 3, 8'h00, 8'h3F, 1'b0, 1'b0);
    // Wrap up: 0xFE + 3
    issue(1'b0, 8'hFE, 4'd3, 8'h00, 5'd7, 1, 8'h3C, 8'h01, 1'b0, 1'b0);
    // Wrap down: 0x00 - 8
    issue(1'b1, 8'h00, 4'h8, 8'h99, 5'd0, 0, 8'h00, 8'hF8, 1'b0, 1'b0);
    // Timeout: no ack
    issue(1'b0, 8'h20, 4'd0, 8'h00, 5'd5, 255, 8'h00, 8'h20, 1'b1, 1'b0);
    @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);
    // Boundary: ack on the TMO-th cycle wins
    issue(1'b0, 8'h30, 4'd1, 8'h00, 5'd9, TMO - 1, 8'h77, 8'h31, 1'b0, 1'b0);
    // Start pulses while busy are ignored
    issue(1'b0, 8'h50, 4'd4, 8'h00, 5'h1F, 3, 8'hE1, 8'h54, 1'b0, 1'b1);

    // Reset in the middle of REQ
    req_q.push_back('{8'h80, 1'b0, 8'h00, 255, 8'h00, TMO});
    start = 1'b1; is_store = 1'b0; base = 8'h7C; offset = 4'd4; dst_addr = 5'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("mid_req_before_rst", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_ctrl", 32'({busy, done, err, mem_req, mem_we, rf_wr_en}), 32'd0);
    chk("rst_data", 32'({mem_addr, mem_wdata, rf_wr_addr, rf_dat}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // New command accepted after reset: 0x12 + 7
    issue(1'b0, 8'h12, 4'd7, 8'h00, 5'd2, 2, 8'h0F, 8'h19, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    chk("req_q_drained", 32'(req_q.size()), 32'd0);
    chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ld_st_unit.md
Name: ld_st_unit

Overview:
- Memory-access stage between the register file and the data memory.
- Consumes the two register-file read ports: base address from port A, store data from port B.
- Performs one load or store per command over a req/ack handshake with the data memory, with a bounded wait.
- Returns load data to the register file through its write port (wr_en / wr_addr / dat_in).

Parameters:
pw, 4, register pointer parameter; register addresses are pw+1 bits wide, matching the register-file write and read address ports
AW, 8, data-memory address width
TMO, 15, maximum cycles mem_req stays high without mem_ack before the access aborts (1..255)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  command strobe, sampled only in IDLE
is_store  in  1  1 = store, 0 = load; sampled with start
base  in  8  base address, from register-file port A
offset  in  4  signed two's-complement address offset
st_data  in  8  store data, from register-file port B
dst_addr  in  pw+1  load destination register
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
err  out  1  sticky timeout flag
mem_req  out  1  memory request
mem_we  out  1  memory write enable, valid while mem_req is high
mem_addr  out  AW  memory address
mem_wdata  out  8  memory write data
mem_rdata  in  8  memory read data, valid with mem_ack
mem_ack  in  1  memory acknowledge
rf_wr_en  out  1  register-file write enable
rf_wr_addr  out  pw+1  register-file write address
rf_dat  out  8  register-file write data

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE, wait counter = 0.
  - All outputs = 0, including err.
  - mem_req drops in the same cycle reset asserts; an abandoned access is not retried.
- All outputs are registered.
- States: IDLE, REQ, RESP.
- IDLE:
  - On start = 1, latch is_store, st_data and dst_addr.
  - Latch mem_addr = base + sign_extend(offset), truncated or zero-extended to AW bits. Wrap-around is modulo 2^AW: base 0xFE + offset +3 gives 0x01; base 0x00 + offset -1 gives 0xFF.
  - Clear err, clear the counter, go to REQ.
  - mem_ack while in IDLE is ignored.
- REQ:
  - mem_req = 1; mem_we = latched is_store; mem_addr and mem_wdata are held stable.
  - On mem_ack = 1:
    - Load: capture mem_rdata into rf_dat.
    - Go to RESP; mem_req = 0 in the following cycle.
  - On no ack: counter increments.
    - When the counter reaches TMO with no ack, go to RESP with err = 1 and no register write.
    - If ack arrives in the same cycle the counter reaches TMO, ack wins and err stays 0.
- RESP (one cycle):
  - done = 1.
  - Load without err: rf_wr_en = 1, rf_wr_addr = latched dst_addr.
  - Store, or err: rf_wr_en = 0.
  - Always returns to IDLE.
- start while busy is ignored; no queuing.
- A start in the cycle immediately after RESP is accepted.
- Latency, ack in first REQ cycle:
  - Start at edge 0, mem_req high after edge 0.
  - done and rf_wr_en high after edge 2.
  - Throughput: one command per 3 cycles minimum.
- err stays high until the next accepted start or reset.
- rf_wr_en is never high outside RESP.
- mem_we is 0 whenever mem_req is 0.

Decomposition:
- Shared package (e.g. cpu_pkg):
  - State enum type ls_state_t {IDLE, REQ, RESP}.
  - Default constants for TMO and AW.
  - Register address width derived from pw.
- One natural sub-module: ls_addr_gen (combinational base + sign-extended offset, modulo 2^AW).
- FSM, counter and output registers stay in the top module.

Test Plan:
- Load, immediate ack: base 0x10, offset +2, dst_addr 3, mem_rdata 0xA5 with ack in first REQ cycle -> mem_addr 0x12, mem_we 0; 2 cycles later done = 1, rf_wr_en = 1, rf_wr_addr 3, rf_dat 0xA5.
- Store, 4-cycle ack delay: base 0x40, offset -1, st_data 0x5C -> mem_addr 0x3F, mem_we 1, mem_wdata 0x5C held 4 cycles; done = 1, rf_wr_en stays 0 throughout.
- Address wrap: base 0xFE, offset +3 -> mem_addr 0x01; base 0x00, offset -8 -> mem_addr 0xF8.
- Timeout: no ack -> mem_req high exactly TMO cycles, then done = 1 and err = 1 with rf_wr_en 0; next start clears err.
- Timeout boundary: ack at cycle TMO -> err 0, load completes normally.
- Busy and reset: start pulses while busy are ignored (exactly one access each); rst_n low mid-REQ -> mem_req, busy and all outputs 0 immediately; after release, IDLE accepts a new start.
